// File: rtl/stb_pkg.sv
// Shared store-buffer definitions.
// Contents: the drain FSM state type and the default address, data and depth
// constants. Those defaults are shared by the LSU-side controller, the store
// buffer datapath and the dcache drain controller.
package stb_pkg;

  localparam int unsigned StbAddrW = 32;
  localparam int unsigned StbDataW = 32;
  localparam int unsigned StbDepth = 8;

  typedef enum logic [1:0] {
    DRN_IDLE,
    DRN_REQ
  } drn_state_t;

endpackage

// File: rtl/stb_dcache_controller.sv
// Drain-side controller of the store buffer.
// It takes the committed store at the head of the store buffer, writes it to
// the data cache over a req/ack handshake, and then pops that entry. Draining
// is held back while a load is waiting for the cache. That hold ends when any
// of these is true: the buffer is full, it reaches the occupancy watermark,
// the LSU requests a fence, or the starvation counter saturates. A fence
// drains the buffer to empty and then reports completion.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stb_empty/full/count       occupancy of the store buffer
//   stb_head_addr/data/sel     head entry, stable from launch until stb_rd_en
//   stb_rd_en                  pop pulse, high in the ack cycle
//   stb2dcache_*               registered write request to the data cache
//   dcache2stb_ack             cache accepted the write
//   lsu_ld_pending             a load is waiting for the cache
//   lsu_fence_req              level request to drain the buffer completely
//   stb2lsu_fence_done         registered fence completion
module stb_dcache_controller
  import stb_pkg::*;
#(
  parameter int unsigned ADDR_W     = StbAddrW,
  parameter int unsigned DATA_W     = StbDataW,
  parameter int unsigned SEL_W      = DATA_W / 8,
  parameter int unsigned DEPTH      = StbDepth,
  parameter int unsigned WATERMARK  = DEPTH / 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stb_empty,
  input  logic                       stb_full,
  input  logic [$clog2(DEPTH+1)-1:0] stb_count,
  input  logic [ADDR_W-1:0]          stb_head_addr,
  input  logic [DATA_W-1:0]          stb_head_data,
  input  logic [SEL_W-1:0]           stb_head_sel,
  output logic                       stb_rd_en,
  output logic                       stb2dcache_req,
  output logic                       stb2dcache_w_en,
  output logic [ADDR_W-1:0]          stb2dcache_addr,
  output logic [DATA_W-1:0]          stb2dcache_wdata,
  output logic [SEL_W-1:0]           stb2dcache_sel,
  input  logic                       dcache2stb_ack,
  input  logic                       lsu_ld_pending,
  input  logic                       lsu_fence_req,
  output logic                       stb2lsu_fence_done
);

  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  localparam logic [CntW-1:0]    WmarkCnt   = CntW'(WATERMARK);
  localparam logic [StarveW-1:0] StarveMaxC = StarveW'(STARVE_MAX);

  drn_state_t          state_q;
  logic                req_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [SEL_W-1:0]    sel_q;
  logic [StarveW-1:0]  starve_q;
  logic                fence_done_q;
  logic                go;

  // A waiting load holds off draining. The hold ends when the buffer is full,
  // reaches the watermark, a fence is pending, or the load has been favoured
  // for STARVE_MAX consecutive cycles.
  always_comb begin
    go = !stb_empty && (!lsu_ld_pending || stb_full || (stb_count >= WmarkCnt) ||
                        lsu_fence_req || (starve_q == StarveMaxC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DRN_IDLE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      sel_q        <= '0;
      starve_q     <= '0;
      fence_done_q <= 1'b0;
    end else begin
      // Completion latches once the buffer is empty with no request in flight.
      // It then holds for as long as the LSU keeps the fence request up.
      fence_done_q <= lsu_fence_req &&
                      (fence_done_q || (stb_empty && (state_q == DRN_IDLE)));

      unique case (state_q)
        DRN_IDLE: begin
          if (go) begin
            addr_q   <= stb_head_addr;
            data_q   <= stb_head_data;
            sel_q    <= stb_head_sel;
            req_q    <= 1'b1;
            starve_q <= '0;
            state_q  <= DRN_REQ;
          end else if (stb_empty) begin
            starve_q <= '0;
          end else if (starve_q != StarveMaxC) begin
            starve_q <= starve_q + StarveW'(1);
          end
        end
        DRN_REQ: begin
          // The FSM always returns to idle after a pop. That spare cycle lets
          // the datapath advance its head before the next launch.
          if (dcache2stb_ack) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            state_q <= DRN_IDLE;
          end
        end
        default: state_q <= DRN_IDLE;
      endcase
    end
  end

  assign stb_rd_en          = (state_q == DRN_REQ) && dcache2stb_ack;
  assign stb2dcache_req     = req_q;
  assign stb2dcache_w_en    = req_q;
  assign stb2dcache_addr    = addr_q;
  assign stb2dcache_wdata   = data_q;
  assign stb2dcache_sel     = sel_q;
  assign stb2lsu_fence_done = fence_done_q;

endmodule

// File: doc/stb_dcache_controller.md
Name: stb_dcache_controller

Overview:
Drain-side controller of the store buffer. It takes the oldest committed store at the head of store_buffer_datapath and writes it to the data cache over a req/ack handshake, then pops that entry. It arbitrates cache access against pending loads using an occupancy watermark and a starvation counter. It also services LSU fence requests by draining the buffer to empty and signalling completion.

Parameters:
ADDR_W, 32, store address width
DATA_W, 32, store data width
SEL_W, DATA_W/8, byte-select width
DEPTH, 8, store buffer entry count
WATERMARK, DEPTH/2, occupancy at or above which draining pre-empts loads
STARVE_MAX, 8, consecutive deferred cycles after which draining pre-empts loads

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
stb_empty  in  1  buffer empty flag from datapath
stb_full  in  1  buffer full flag from datapath
stb_count  in  $clog2(DEPTH+1)  current occupancy
stb_head_addr  in  ADDR_W  head entry address
stb_head_data  in  DATA_W  head entry data
stb_head_sel  in  SEL_W  head entry byte select
stb_rd_en  out  1  pop head entry, one-cycle pulse
stb2dcache_req  out  1  cache write request
stb2dcache_w_en  out  1  write enable, always equal to req
stb2dcache_addr  out  ADDR_W  write address
stb2dcache_wdata  out  DATA_W  write data
stb2dcache_sel  out  SEL_W  byte select
dcache2stb_ack  in  1  cache accepted/completed write
lsu_ld_pending  in  1  a load is waiting for the cache
lsu_fence_req  in  1  level; LSU requests full drain
stb2lsu_fence_done  out  1  buffer drained under fence

Behaviour:
- Reset value of every output is 0. State resets to DRN_IDLE and starve_cnt resets to 0.
- The FSM has two states: DRN_IDLE and DRN_REQ.
- go = !stb_empty && (!lsu_ld_pending || stb_full || stb_count>=WATERMARK || lsu_fence_req || starve_cnt==STARVE_MAX).
- DRN_IDLE with go=1:
  - Register head addr/data/sel into the stb2dcache_* outputs.
  - Set req=w_en=1 and move to DRN_REQ. req is visible in the next cycle.
- DRN_IDLE with go=0: stay in DRN_IDLE; outputs hold 0.
- DRN_REQ:
  - addr/data/sel/req are held stable until ack.
  - In the cycle dcache2stb_ack=1, stb_rd_en=1 (combinational, that same cycle).
  - The registered req/w_en clear and the FSM returns to DRN_IDLE.
- Throughput is at most one store per 2 cycles plus cache latency. The cycle after a pop is always spent in DRN_IDLE so the datapath head can advance.
- dcache2stb_ack in DRN_IDLE is ignored: no pop, no state change.
- lsu_ld_pending does not affect an in-flight request.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each DRN_IDLE cycle with stb_empty=0 and go=0.
  - Clears on launch or when stb_empty=1.
  - Width is $clog2(STARVE_MAX+1).
- Fence:
  - stb2lsu_fence_done is registered. It sets the cycle after lsu_fence_req && stb_empty && state==DRN_IDLE.
  - It stays set while lsu_fence_req=1.
  - It clears the cycle after lsu_fence_req falls.
  - Fence forces go (loads are deferred) until empty.
- Datapath obligation: head fields are stable from launch until stb_rd_en. Concurrent LSU writes may raise stb_count but must not alter the head.
- Simultaneous events:
  - With stb_full and lsu_ld_pending both high, the drain wins.
  - With fence, full and ld all high, the drain wins.
- Reset mid-request: an async reset drops req, w_en and stb_rd_en immediately. No pop occurs. After release, the same head is relaunched.

Decomposition:
- Package stb_pkg holds:
  - typedef enum logic [1:0] drn_state_t {DRN_IDLE, DRN_REQ}
  - default ADDR_W/DATA_W/DEPTH constants, shared with lsu_stb_controller and store_buffer_datapath
- No sub-module is needed. The starvation counter and FSM live in this single module.

Test Plan:
1. Single store. Stimulus: count=1, head 0x0000_1000/0xDEAD_BEEF/4'b1111, ld_pending=0; ack 3 cycles after req. Response: req/w_en rise 1 cycle after launch with matching addr/data/sel; exactly one stb_rd_en pulse in the ack cycle; req low the next cycle.
2. Back-to-back drain. Stimulus: 3 entries, ack same cycle as req. Response: 3 pops, req asserted every 2nd cycle, entries in FIFO order, stb_empty reached with no extra pop.
3. Starvation. Stimulus: ld_pending=1 held, count=1, WATERMARK=4, STARVE_MAX=8. Response: no req for 9 deferred decision cycles; req asserted in the 10th cycle; starve_cnt returns to 0.
4. Watermark/full. Stimulus: ld_pending=1 with count=4; then a separate run with count=1 and stb_full forced. Response: both launch immediately (req on next cycle).
5. Fence. Stimulus: count=2, ld_pending=1, fence_req held. Response: both entries drained back-to-back; fence_done=1 one cycle after empty in DRN_IDLE; fence_done=0 one cycle after fence_req drops.
6. Reset mid-request. Stimulus: rst_n low while req=1 awaiting ack, with ack asserted during reset. Response: all outputs 0 immediately and no stb_rd_en; after release, the same head address is requested again.
